// File: rtl/uv_pred_gen_pkg.sv
// uv_pred_gen_pkg: shared chroma-prediction definitions.
// Holds the mode encodings, the fill values used when neighbours are missing,
// the FSM state type, the byte layout used by the reconstruct stage, and the DC rule.
package uv_pred_gen_pkg;

  typedef enum logic [1:0] {
    UV_MODE_DC = 2'd0,
    UV_MODE_TM = 2'd1,
    UV_MODE_VE = 2'd2,
    UV_MODE_HE = 2'd3
  } uv_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUM,
    ST_GEN,
    ST_FIN
  } uv_state_e;

  localparam logic [7:0] UV_FILL_VE = 8'd127;
  localparam logic [7:0] UV_FILL_DC = 8'd128;
  localparam logic [7:0] UV_FILL_HE = 8'd129;

  // Byte index into UVPred: row*16 + col, col 0..7 = U, col 8..15 = V.
  function automatic logic [6:0] uv_byte_idx(input logic [2:0] row, input logic [3:0] col);
    return {row, col};
  endfunction

  // DC value for one plane from the 11-bit top/left sums and availability.
  function automatic logic [7:0] uv_dc(input logic       top_avail,
                                       input logic       left_avail,
                                       input logic [10:0] sum_t,
                                       input logic [10:0] sum_l);
    logic [11:0] s;
    logic [7:0]  r;
    s = '0;
    r = UV_FILL_DC;
    if (top_avail && left_avail) begin
      s = {1'b0, sum_t} + {1'b0, sum_l} + 12'd8;
      r = s[11:4];
    end else if (top_avail) begin
      s = {1'b0, sum_t} + 12'd4;
      r = s[10:3];
    end else if (left_avail) begin
      s = {1'b0, sum_l} + 12'd4;
      r = s[10:3];
    end
    return r;
  endfunction

endpackage

// File: rtl/uv_pred_gen_row.sv
// uv_pred_row: combinational row builder for one chroma plane.
// Produces the 8 bytes of the current row from mode, availability, DC value,
// top row, the current row's left sample and the corner sample.
// Optional feature macro: UV_PRED_TM_EN (TrueMotion datapath).
module uv_pred_row
  import uv_pred_gen_pkg::*;
#(
  parameter int unsigned BLOCK_W = 8
) (
  input  uv_mode_e    mode_i,
  input  logic        top_avail_i,
  input  logic        left_avail_i,
  input  logic [7:0]  dc_i,
  input  logic [63:0] top_i,
  input  logic [7:0]  left_i,
  input  logic [7:0]  top_left_i,
  output logic [63:0] row_o
);

`ifdef UV_PRED_TM_EN
  logic signed [9:0] tm;
`else
  logic unused_top_left;
  assign unused_top_left = ^top_left_i;
`endif

  // Per-pixel selection of the prediction for the current row.
  always_comb begin
    row_o = '0;
`ifdef UV_PRED_TM_EN
    tm    = '0;
`endif
    for (int unsigned c = 0; c < BLOCK_W; c++) begin
      unique case (mode_i)
        UV_MODE_VE: row_o[c*8 +: 8] = top_avail_i ? top_i[c*8 +: 8] : UV_FILL_VE;
        UV_MODE_HE: row_o[c*8 +: 8] = left_avail_i ? left_i : UV_FILL_HE;
`ifdef UV_PRED_TM_EN
        UV_MODE_TM: begin
          // Degenerate cases collapse onto HE / VE / 129 when a neighbour is missing.
          if (top_avail_i && left_avail_i) begin
            tm = $signed({2'b00, top_i[c*8 +: 8]}) + $signed({2'b00, left_i})
               - $signed({2'b00, top_left_i});
            if (tm < 0)
              row_o[c*8 +: 8] = 8'd0;
            else if (tm > 10'sd255)
              row_o[c*8 +: 8] = 8'd255;
            else
              row_o[c*8 +: 8] = tm[7:0];
          end else if (left_avail_i) begin
            row_o[c*8 +: 8] = left_i;
          end else if (top_avail_i) begin
            row_o[c*8 +: 8] = top_i[c*8 +: 8];
          end else begin
            row_o[c*8 +: 8] = UV_FILL_HE;
          end
        end
`endif
        default: row_o[c*8 +: 8] = dc_i;
      endcase
    end
  end

endmodule

// File: rtl/uv_pred_gen.sv
// uv_pred_gen: chroma 8x8 U/V intra predictor (DC, TM, VE, HE) for one macroblock.
// Flow: IDLE -> SUM (DC sums, 1 cycle) -> GEN (8 rows) -> FIN (done) -> IDLE.
// Optional feature macro: UV_PRED_TM_EN; when undefined, mode 1 behaves as DC.
module uv_pred_gen
  import uv_pred_gen_pkg::*;
#(
  parameter int unsigned BLOCK_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic [63:0]   top_u,
  input  logic [63:0]   top_v,
  input  logic [63:0]   left_u,
  input  logic [63:0]   left_v,
  input  logic [7:0]    top_left_u,
  input  logic [7:0]    top_left_v,
  output logic [1023:0] UVPred,
  output logic          busy,
  output logic          done
);

  uv_state_e     state_q;
  logic [2:0]    row_q;
  logic          busy_q;
  logic          done_q;
  logic [1023:0] pred_q;

  uv_mode_e      mode_q;
  logic          top_avail_q;
  logic          left_avail_q;
  logic [63:0]   top_u_q;
  logic [63:0]   top_v_q;
  logic [63:0]   left_u_q;
  logic [63:0]   left_v_q;
  logic [7:0]    tl_u_q;
  logic [7:0]    tl_v_q;
  logic [7:0]    dc_u_q;
  logic [7:0]    dc_v_q;

  logic [10:0]   sum_tu_d;
  logic [10:0]   sum_tv_d;
  logic [10:0]   sum_lu_d;
  logic [10:0]   sum_lv_d;
  logic [63:0]   row_u;
  logic [63:0]   row_v;

  assign UVPred = pred_q;
  assign busy   = busy_q;
  assign done   = done_q;

  // Neighbour sums over the captured top row and left column of each plane.
  always_comb begin
    sum_tu_d = '0;
    sum_tv_d = '0;
    sum_lu_d = '0;
    sum_lv_d = '0;
    for (int unsigned k = 0; k < BLOCK_W; k++) begin
      sum_tu_d = sum_tu_d + {3'b000, top_u_q[k*8 +: 8]};
      sum_tv_d = sum_tv_d + {3'b000, top_v_q[k*8 +: 8]};
      sum_lu_d = sum_lu_d + {3'b000, left_u_q[k*8 +: 8]};
      sum_lv_d = sum_lv_d + {3'b000, left_v_q[k*8 +: 8]};
    end
  end

  uv_pred_row #(.BLOCK_W(BLOCK_W)) u_row_u (
    .mode_i       (mode_q),
    .top_avail_i  (top_avail_q),
    .left_avail_i (left_avail_q),
    .dc_i         (dc_u_q),
    .top_i        (top_u_q),
    .left_i       (left_u_q[row_q*8 +: 8]),
    .top_left_i   (tl_u_q),
    .row_o        (row_u)
  );

  uv_pred_row #(.BLOCK_W(BLOCK_W)) u_row_v (
    .mode_i       (mode_q),
    .top_avail_i  (top_avail_q),
    .left_avail_i (left_avail_q),
    .dc_i         (dc_v_q),
    .top_i        (top_v_q),
    .left_i       (left_v_q[row_q*8 +: 8]),
    .top_left_i   (tl_v_q),
    .row_o        (row_v)
  );

  // Control FSM, input capture, DC registers and row-by-row output writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pred_q       <= '0;
      mode_q       <= UV_MODE_DC;
      top_avail_q  <= 1'b0;
      left_avail_q <= 1'b0;
      top_u_q      <= '0;
      top_v_q      <= '0;
      left_u_q     <= '0;
      left_v_q     <= '0;
      tl_u_q       <= '0;
      tl_v_q       <= '0;
      dc_u_q       <= '0;
      dc_v_q       <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_q       <= uv_mode_e'(mode);
            top_avail_q  <= |y;
            left_avail_q <= |x;
            top_u_q      <= top_u;
            top_v_q      <= top_v;
            left_u_q     <= left_u;
            left_v_q     <= left_v;
            tl_u_q       <= top_left_u;
            tl_v_q       <= top_left_v;
            busy_q       <= 1'b1;
            state_q      <= ST_SUM;
          end
        end
        ST_SUM: begin
          dc_u_q  <= uv_dc(top_avail_q, left_avail_q, sum_tu_d, sum_lu_d);
          dc_v_q  <= uv_dc(top_avail_q, left_avail_q, sum_tv_d, sum_lv_d);
          row_q   <= '0;
          state_q <= ST_GEN;
        end
        ST_GEN: begin
          for (int unsigned c = 0; c < BLOCK_W; c++) begin
            pred_q[{uv_byte_idx(row_q, 4'(c)), 3'b000} +: 8]     <= row_u[c*8 +: 8];
            pred_q[{uv_byte_idx(row_q, 4'(c + 8)), 3'b000} +: 8] <= row_v[c*8 +: 8];
          end
          if (row_q == 3'(BLOCK_W - 1)) begin
            row_q   <= '0;
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end else begin
            row_q <= row_q + 3'd1;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uv_pred_gen.sv
// Scoreboard bench for uv_pred_gen: expected predictions are pushed at start,
// a negedge monitor pops and compares whenever done is seen.
module tb_uv_pred_gen;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [9:0]    x;
  logic [9:0]    y;
  logic [63:0]   top_u, top_v, left_u, left_v;
  logic [7:0]    top_left_u, top_left_v;
  logic [1023:0] UVPred;
  logic          busy;
  logic          done;

  uv_pred_gen #(.BLOCK_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .x          (x),
    .y          (y),
    .top_u      (top_u),
    .top_v      (top_v),
    .left_u     (left_u),
    .left_v     (left_v),
    .top_left_u (top_left_u),
    .top_left_v (top_left_v),
    .UVPred     (UVPred),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic [1023:0] exp_q[$];
  int            cyc_q[$];

  // Stimulus description the model works from.
  int        m;
  logic [9:0] xs, ys;
  int        tu[8], tv[8], lu[8], lv[8];
  int        tlu, tlv;

  function automatic int clip255(int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int pel(int pl, int r, int c);
    int  top[8];
    int  left[8];
    int  tl, t_sum, l_sum, dc, eff;
    bit  ta, la;
    ta = (ys != 0);
    la = (xs != 0);
    for (int i = 0; i < 8; i++) begin
      top[i]  = (pl == 0) ? tu[i] : tv[i];
      left[i] = (pl == 0) ? lu[i] : lv[i];
    end
    tl = (pl == 0) ? tlu : tlv;
    t_sum = 0;
    l_sum = 0;
    for (int i = 0; i < 8; i++) begin
      t_sum += top[i];
      l_sum += left[i];
    end
    if (ta && la)  dc = (t_sum + l_sum + 8) / 16;
    else if (ta)   dc = (t_sum + 4) / 8;
    else if (la)   dc = (l_sum + 4) / 8;
    else           dc = 128;
    eff = m;
`ifndef UV_PRED_TM_EN
    if (eff == 1) eff = 0;
`endif
    case (eff)
      1: begin
        if (ta && la) return clip255(top[c] + left[r] - tl);
        if (la) return left[r];
        if (ta) return top[c];
        return 129;
      end
      2: return ta ? top[c] : 127;
      3: return la ? left[r] : 129;
      default: return dc;
    endcase
  endfunction

  function automatic logic [1023:0] model();
    logic [1023:0] out;
    int v;
    out = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++) begin
        v = pel(c / 8, r, c % 8);
        out[(r*16 + c)*8 +: 8] = 8'(v);
      end
    return out;
  endfunction

  task automatic drive_inputs();
    mode = 2'(m);
    x = xs;
    y = ys;
    for (int k = 0; k < 8; k++) begin
      top_u[k*8 +: 8]  = 8'(tu[k]);
      top_v[k*8 +: 8]  = 8'(tv[k]);
      left_u[k*8 +: 8] = 8'(lu[k]);
      left_v[k*8 +: 8] = 8'(lv[k]);
    end
    top_left_u = 8'(tlu);
    top_left_v = 8'(tlv);
  endtask

  task automatic scramble();
    mode = 2'($urandom);
    x = 10'($urandom);
    y = 10'($urandom);
    top_u  = {$urandom, $urandom};
    top_v  = {$urandom, $urandom};
    left_u = {$urandom, $urandom};
    left_v = {$urandom, $urandom};
    top_left_u = 8'($urandom);
    top_left_v = 8'($urandom);
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, expv);
    end
  endtask

  function automatic logic [9:0] rand_pos();
    case ($urandom % 4)
      0: return 10'd0;
      1: return 10'd1023;
      default: return 10'($urandom_range(1, 1022));
    endcase
  endfunction

  task automatic rand_txn();
    m = int'($urandom % 4);
    xs = rand_pos();
    ys = rand_pos();
    for (int k = 0; k < 8; k++) begin
      tu[k] = int'($urandom % 256);
      tv[k] = int'($urandom % 256);
      lu[k] = int'($urandom % 256);
      lv[k] = int'($urandom % 256);
    end
    tlu = int'($urandom % 256);
    tlv = int'($urandom % 256);
  endtask

  task automatic set_all(int t, int l, int tl);
    for (int k = 0; k < 8; k++) begin
      tu[k] = t; tv[k] = t; lu[k] = l; lv[k] = l;
    end
    tlu = tl;
    tlv = tl;
  endtask

  // Issue one request at the current cycle, optionally firing ignored starts
  // at relative cycles 3 and 10; returns at relative cycle 11.
  task automatic run(bit inject);
    drive_inputs();
    start = 1'b1;
    exp_q.push_back(model());
    cyc_q.push_back(cyc + 10);
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    check("busy_after_start", 32'(busy), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      if (inject && (k == 3 || k == 10)) begin
        scramble();
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("busy_cleared", 32'(busy), 32'd0);
  endtask

  // Monitor: compare each done against the oldest expected result.
  logic [1023:0] mon_exp;
  int            mon_cyc;
  int            bad_byte;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done cyc=%0d got=1 exp=0", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = cyc_q.pop_front();
        checks++;
        if (cyc != mon_cyc) begin
          failures++;
          $display("FAIL done_latency got_cyc=%0d exp_cyc=%0d", cyc, mon_cyc);
        end
        checks++;
        if (UVPred !== mon_exp) begin
          failures++;
          bad_byte = -1;
          for (int b = 127; b >= 0; b--)
            if (UVPred[b*8 +: 8] !== mon_exp[b*8 +: 8]) bad_byte = b;
          $display("FAIL pred_data cyc=%0d byte=%0d got=%0d exp=%0d", cyc, bad_byte,
                   UVPred[bad_byte*8 +: 8], mon_exp[bad_byte*8 +: 8]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = '0; x = '0; y = '0;
    top_u = '0; top_v = '0; left_u = '0; left_v = '0;
    top_left_u = '0; top_left_v = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_pred_zero", 32'(UVPred == '0), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // DC both available -> 15
    m = 0; xs = 10'd1; ys = 10'd1; set_all(10, 20, 0); run(0);
    // DC neither -> 128
    m = 0; xs = 10'd0; ys = 10'd0; set_all(77, 99, 5); run(0);
    // DC top only, top = 0..7 -> 4
    m = 0; xs = 10'd0; ys = 10'd1; set_all(0, 200, 0);
    for (int k = 0; k < 8; k++) begin tu[k] = k; tv[k] = k; end
    run(0);
    // VE no top -> 127
    m = 2; xs = 10'd5; ys = 10'd0; set_all(33, 44, 0); run(0);
    // HE left_u row r = r*30, left_v random
    m = 3; xs = 10'd1; ys = 10'd7; rand_txn(); m = 3; xs = 10'd1;
    for (int k = 0; k < 8; k++) lu[k] = k * 30;
    run(0);
    // TM clip high / clip low
    m = 1; xs = 10'd1; ys = 10'd1; set_all(250, 20, 10); run(0);
    m = 1; xs = 10'd1; ys = 10'd1; set_all(5, 0, 100); run(0);
    // TM left missing, and maximum coordinates
    m = 1; xs = 10'd0; ys = 10'd1; rand_txn(); m = 1; xs = 10'd0; ys = 10'd1; run(0);
    m = 1; xs = 10'd1023; ys = 10'd1023; rand_txn(); m = 1; xs = 10'd1023; ys = 10'd1023; run(1);

    // Randomised back-to-back traffic, some with ignored starts mid-run.
    for (int i = 0; i < 25; i++) begin
      rand_txn();
      run(i % 3 == 0);
    end

    // Reset at relative cycle 5: outputs clear, no done afterwards.
    rand_txn();
    drive_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pred_zero", 32'(UVPred == '0), 32'd1);
    repeat (15) @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) begin
      rand_txn();
      run(0);
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
